dram_device: RTL and testbench

Cycle-accurate DRAM device responder: the memory end of the row/column command interface driven by the team's DRAM controller wrappers. Decodes CSn/RASn/CASn/WEn commands, tracks one open row through activate/precharge timing, performs byte-masked writes, and returns read data through a CAS-latency pipeline with a `VALID` pulse. Used in the top-level testbench and in system simulation in place of the external DRAM macro.

---
 rtl/dram_device.sv | 175 +++++++++++++++++
 tb/tb_dram_device.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_device.sv
// Cycle-accurate DRAM device responder: one open row, byte-masked writes, CL-deep read pipeline.
// Optional macro DRAM_DEVICE_TIMING_CHECK_EN enables tRCD/tRP timers and the ERR pulse.
//
// state       | meaning
// IDLE        | row closed, ACT accepted
// ACTIVATING  | tRCD timer running after ACT
// ACTIVE      | row open, RD/WR/PRE accepted
// PRECHARGING | tRP timer running after PRE
module dram_device #(
    parameter int ROW_BITS = 11,
    parameter int COL_BITS = 10,
    parameter int TRCD     = 5,
    parameter int TRP      = 5,
    parameter int CL       = 5,
    parameter int A_BITS   = (ROW_BITS > COL_BITS) ? ROW_BITS : COL_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CSn,
    input  logic              RASn,
    input  logic              CASn,
    input  logic [3:0]        WEn,
    input  logic [A_BITS-1:0] A,
    input  logic [31:0]       D,
    output logic [31:0]       Q,
    output logic              VALID,
    output logic              ERR
);
    localparam int ADDR_BITS = ROW_BITS + COL_BITS;

    typedef enum logic [1:0] {IDLE, ACTIVATING, ACTIVE, PRECHARGING} state_t;

    state_t              state;
    logic [ROW_BITS-1:0] open_row;
    logic [COL_BITS-1:0] col;
    logic [ADDR_BITS-1:0] addr;
    logic [31:0]         rd_word;
    logic                we_none;
    logic                cmd_act, cmd_pre, cmd_rd, cmd_wr;
    logic                act_ok, pre_ok, rd_ok, wr_ok;
    logic                tail_v;
    logic [31:0]         tail_d;

    logic [31:0] mem [0:(2**ADDR_BITS)-1];

    assign col     = A[COL_BITS-1:0];
    assign addr    = {open_row, col};
    assign rd_word = mem[addr];
    assign we_none = (WEn == 4'hF);

    assign cmd_act = !CSn && !RASn &&  CASn &&  we_none;
    assign cmd_pre = !CSn && !RASn &&  CASn && !we_none;
    assign cmd_rd  = !CSn &&  RASn && !CASn &&  we_none;
    assign cmd_wr  = !CSn &&  RASn && !CASn && !we_none;

    assign act_ok = cmd_act && (state == IDLE);
    assign pre_ok = cmd_pre && (state == ACTIVE);
    assign rd_ok  = cmd_rd  && (state == ACTIVE);
    assign wr_ok  = cmd_wr  && (state == ACTIVE);

    // Storage has no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (!WEn[i]) mem[addr][8*i +: 8] <= D[8*i +: 8];
            end
        end
    end

`ifdef DRAM_DEVICE_TIMING_CHECK_EN
    localparam int TMAX = (TRCD > TRP) ? TRCD : TRP;
    localparam int TW   = $clog2(TMAX + 1);

    logic [TW-1:0] timer;
    logic          cmd_ill;
    logic          reject;

    assign cmd_ill = !CSn && !RASn && !CASn;
    assign reject  = (cmd_act && !act_ok) || (cmd_pre && !pre_ok) ||
                     (cmd_rd && !rd_ok) || (cmd_wr && !wr_ok) || cmd_ill;

    // Timer holds remaining wait cycles; leaving on 1 makes the new state visible exactly TRCD/TRP after the command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            open_row <= '0;
            ERR      <= 1'b0;
        end else begin
            ERR <= reject;
            case (state)
                IDLE: begin
                    if (act_ok) begin
                        open_row <= A[ROW_BITS-1:0];
                        timer    <= TW'(TRCD - 1);
                        state    <= (TRCD == 1) ? ACTIVE : ACTIVATING;
                    end
                end
                ACTIVATING: begin
                    timer <= timer - TW'(1);
                    if (timer == TW'(1)) state <= ACTIVE;
                end
                ACTIVE: begin
                    if (pre_ok) begin
                        timer <= TW'(TRP - 1);
                        state <= (TRP == 1) ? IDLE : PRECHARGING;
                    end
                end
                PRECHARGING: begin
                    timer <= timer - TW'(1);
                    if (timer == TW'(1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign ERR = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            open_row <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (act_ok) begin
                        open_row <= A[ROW_BITS-1:0];
                        state    <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (pre_ok) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

    // First CL-1 stages live here; the output register is the last stage.
    generate
        if (CL > 1) begin : g_pipe
            localparam int PW = CL - 1;
            logic [PW-1:0] pv;
            logic [31:0]   pd [PW];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) pv <= '0;
                else     pv <= (pv << 1) | PW'(rd_ok);
            end

            always_ff @(posedge clk) begin
                pd[0] <= rd_word;
                for (int i = 1; i < PW; i++) pd[i] <= pd[i-1];
            end

            assign tail_v = pv[PW-1];
            assign tail_d = pd[PW-1];
        end else begin : g_direct
            assign tail_v = rd_ok;
            assign tail_d = rd_word;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Q     <= '0;
            VALID <= 1'b0;
        end else begin
            VALID <= tail_v;
            if (tail_v) Q <= tail_d;
        end
    end
endmodule

// File: tb/tb_dram_device.sv
// Self-checking bench for dram_device: directed vector table, corner-case sequences and
// randomized commands compared against a command-level reference model.
module tb_dram_device;
    localparam int TRCD = 5;
    localparam int TRP  = 5;
    localparam int CL   = 5;
`ifdef DRAM_DEVICE_TIMING_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    localparam int K_NOP = 0, K_ACT = 1, K_PRE = 2, K_RD = 3, K_WR = 4, K_ILL = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        CSn = 1'b1, RASn = 1'b1, CASn = 1'b1;
    logic [3:0]  WEn = 4'hF;
    logic [10:0] A = '0;
    logic [31:0] D = '0;
    logic [31:0] Q;
    logic        VALID, ERR;

    dram_device #(.ROW_BITS(11), .COL_BITS(10), .TRCD(TRCD), .TRP(TRP), .CL(CL)) dut (
        .clk(clk), .rst(rst), .CSn(CSn), .RASn(RASn), .CASn(CASn),
        .WEn(WEn), .A(A), .D(D), .Q(Q), .VALID(VALID), .ERR(ERR)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: open/closed row plus the first cycle at which new commands are legal.
    bit          m_open  = 1'b0;
    int          m_ready = 0;
    logic [10:0] m_row   = '0;
    logic [31:0] mm [int];
    logic [3:0]  mkn [int];
    bit          ev_q [int];
    logic [31:0] ed_q [int];
    bit          ek_q [int];
    bit          ee_q [int];
    logic [31:0] q_exp   = '0;
    bit          q_known = 1'b1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, exp);
        end
    endtask

    task automatic model_check();
        bit vexp;
        vexp = ev_q.exists(cyc);
        if (vexp) begin
            if (ek_q[cyc]) begin
                q_exp   = ed_q[cyc];
                q_known = 1'b1;
            end else begin
                q_known = 1'b0;
            end
        end
        chk("model_valid", {31'd0, VALID}, {31'd0, vexp});
        chk("model_err", {31'd0, ERR}, {31'd0, ee_q.exists(cyc)});
        if (q_known) chk("model_q", Q, q_exp);
    endtask

    task automatic model_step(input bit r, input logic cs, input logic ras, input logic cas,
                              input logic [3:0] we, input logic [10:0] a, input logic [31:0] d);
        bit acc, ok;
        int key;
        logic [31:0] w;
        logic [3:0]  km;
        if (r) begin
            ev_q.delete(); ed_q.delete(); ek_q.delete(); ee_q.delete();
            m_open = 1'b0; m_ready = 0; q_exp = '0; q_known = 1'b1;
            return;
        end
        if (cs) return;
        ok  = (cyc >= m_ready);
        acc = 1'b0;
        key = int'({m_row, a[9:0]});
        if (!ras && !cas) begin
            acc = 1'b0;
        end else if (ras && cas) begin
            acc = 1'b1;
        end else if (!ras && we == 4'hF) begin
            acc = !m_open && ok;
            if (acc) begin
                m_open = 1'b1; m_row = a; m_ready = cyc + (CHK ? TRCD : 1);
            end
        end else if (!ras) begin
            acc = m_open && ok;
            if (acc) begin
                m_open = 1'b0; m_ready = cyc + (CHK ? TRP : 1);
            end
        end else begin
            acc = m_open && ok;
            if (acc) begin
                w  = mm.exists(key)  ? mm[key]  : 32'd0;
                km = mkn.exists(key) ? mkn[key] : 4'd0;
                if (we == 4'hF) begin
                    ev_q[cyc + CL] = 1'b1;
                    ed_q[cyc + CL] = w;
                    ek_q[cyc + CL] = (km == 4'hF);
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        if (!we[i]) begin
                            w[8*i +: 8] = d[8*i +: 8];
                            km[i] = 1'b1;
                        end
                    end
                    mm[key] = w; mkn[key] = km;
                end
            end
        end
        if (!acc && CHK) ee_q[cyc + 1] = 1'b1;
    endtask

    task automatic cycle(input bit r, input logic cs, input logic ras, input logic cas,
                         input logic [3:0] we, input logic [10:0] a, input logic [31:0] d);
        model_check();
        rst = r; CSn = cs; RASn = ras; CASn = cas; WEn = we; A = a; D = d;
        model_step(r, cs, ras, cas, we, a, d);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [6:0] fields(input int k, input logic [3:0] we);
        case (k)
            K_ACT:   return {1'b0, 1'b0, 1'b1, 4'hF};
            K_PRE:   return {1'b0, 1'b0, 1'b1, (we == 4'hF) ? 4'h0 : we};
            K_RD:    return {1'b0, 1'b1, 1'b0, 4'hF};
            K_WR:    return {1'b0, 1'b1, 1'b0, (we == 4'hF) ? 4'h0 : we};
            K_ILL:   return {1'b0, 1'b0, 1'b0, we};
            default: return {1'b1, 1'b1, 1'b1, 4'hF};
        endcase
    endfunction

    task automatic cmd(input int k, input logic [10:0] a, input logic [31:0] d, input logic [3:0] we);
        logic [6:0] f;
        f = fields(k, we);
        cycle(1'b0, f[6], f[5], f[4], f[3:0], a, d);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) cmd(K_NOP, 11'd0, 32'd0, 4'hF);
    endtask

    typedef struct {
        int          k;
        logic [10:0] a;
        logic [31:0] d;
        logic [3:0]  we;
        logic        ev;
        logic [31:0] eq;
    } vec_t;

    vec_t tbl [29];

    function automatic vec_t mkv(input int k, input logic [10:0] a, input logic [31:0] d,
                                 input logic [3:0] we, input logic ev, input logic [31:0] eq);
        vec_t v;
        v.k = k; v.a = a; v.d = d; v.we = we; v.ev = ev; v.eq = eq;
        return v;
    endfunction

    initial begin
        int k, rr;
        logic [10:0] a;

        // Rows hold the command for a cycle and the outputs seen during that same cycle.
        tbl[0]  = mkv(K_ACT, 11'h005, 32'h0, 4'hF, 1'b0, 32'h0);
        for (int i = 1; i <= 4; i++) tbl[i] = mkv(K_NOP, 11'h0, 32'h0, 4'hF, 1'b0, 32'h0);
        tbl[5]  = mkv(K_WR,  11'h010, 32'hDEADBEEF, 4'h0, 1'b0, 32'h0);
        tbl[6]  = mkv(K_RD,  11'h010, 32'h0, 4'hF, 1'b0, 32'h0);
        for (int i = 7; i <= 10; i++) tbl[i] = mkv(K_NOP, 11'h0, 32'h0, 4'hF, 1'b0, 32'h0);
        tbl[11] = mkv(K_NOP, 11'h000, 32'h0, 4'hF, 1'b1, 32'hDEADBEEF);
        tbl[12] = mkv(K_WR,  11'h020, 32'h11223344, 4'h0, 1'b0, 32'hDEADBEEF);
        tbl[13] = mkv(K_WR,  11'h020, 32'hAABBCCDD, 4'b1010, 1'b0, 32'hDEADBEEF);
        tbl[14] = mkv(K_RD,  11'h020, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF);
        tbl[15] = mkv(K_WR,  11'h000, 32'h000000A0, 4'h0, 1'b0, 32'hDEADBEEF);
        tbl[16] = mkv(K_WR,  11'h001, 32'h000000A1, 4'h0, 1'b0, 32'hDEADBEEF);
        tbl[17] = mkv(K_WR,  11'h002, 32'h000000A2, 4'h0, 1'b0, 32'hDEADBEEF);
        tbl[18] = mkv(K_WR,  11'h003, 32'h000000A3, 4'h0, 1'b0, 32'hDEADBEEF);
        tbl[19] = mkv(K_RD,  11'h000, 32'h0, 4'hF, 1'b1, 32'h11BB33DD);
        tbl[20] = mkv(K_RD,  11'h001, 32'h0, 4'hF, 1'b0, 32'h11BB33DD);
        tbl[21] = mkv(K_RD,  11'h002, 32'h0, 4'hF, 1'b0, 32'h11BB33DD);
        tbl[22] = mkv(K_RD,  11'h003, 32'h0, 4'hF, 1'b0, 32'h11BB33DD);
        tbl[23] = mkv(K_NOP, 11'h000, 32'h0, 4'hF, 1'b0, 32'h11BB33DD);
        tbl[24] = mkv(K_NOP, 11'h000, 32'h0, 4'hF, 1'b1, 32'h000000A0);
        tbl[25] = mkv(K_NOP, 11'h000, 32'h0, 4'hF, 1'b1, 32'h000000A1);
        tbl[26] = mkv(K_NOP, 11'h000, 32'h0, 4'hF, 1'b1, 32'h000000A2);
        tbl[27] = mkv(K_NOP, 11'h000, 32'h0, 4'hF, 1'b1, 32'h000000A3);
        tbl[28] = mkv(K_NOP, 11'h000, 32'h0, 4'hF, 1'b0, 32'h000000A3);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_q", Q, 32'h0);
        chk("reset_valid", {31'd0, VALID}, 32'd0);
        chk("reset_err", {31'd0, ERR}, 32'd0);

        for (int i = 0; i < 29; i++) begin
            chk("tbl_valid", {31'd0, VALID}, {31'd0, tbl[i].ev});
            chk("tbl_q", Q, tbl[i].eq);
            cmd(tbl[i].k, tbl[i].a, tbl[i].d, tbl[i].we);
        end

        // Early ACT during precharge, then early RD during activation.
        cmd(K_PRE, 11'h0, 32'h0, 4'h0);
        nops(2);
        cmd(K_ACT, 11'h005, 32'h0, 4'hF);
`ifdef DRAM_DEVICE_TIMING_CHECK_EN
        chk("t4_act_early_err", {31'd0, ERR}, 32'd1);
`endif
        nops(1);
        cmd(K_ACT, 11'h005, 32'h0, 4'hF);
        chk("t4_act_ok_noerr", {31'd0, ERR}, 32'd0);
        nops(1);
        cmd(K_RD, 11'h010, 32'h0, 4'hF);
`ifdef DRAM_DEVICE_TIMING_CHECK_EN
        chk("t4_rd_early_err", {31'd0, ERR}, 32'd1);
`endif
        nops(4);
`ifdef DRAM_DEVICE_TIMING_CHECK_EN
        chk("t4_no_valid", {31'd0, VALID}, 32'd0);
`else
        chk("t4_rd_valid", {31'd0, VALID}, 32'd1);
        chk("t4_rd_q", Q, 32'hDEADBEEF);
`endif

        // Read in flight survives a later write and precharge.
        cmd(K_RD, 11'h020, 32'h0, 4'hF);
        cmd(K_WR, 11'h020, 32'h55667788, 4'h0);
        cmd(K_PRE, 11'h0, 32'h0, 4'h0);
        nops(2);
        chk("t5_old_valid", {31'd0, VALID}, 32'd1);
        chk("t5_old_q", Q, 32'h11BB33DD);
        nops(2);
        cmd(K_ACT, 11'h005, 32'h0, 4'hF);
        nops(4);
        cmd(K_RD, 11'h020, 32'h0, 4'hF);
        nops(4);
        chk("t5_new_valid", {31'd0, VALID}, 32'd1);
        chk("t5_new_q", Q, 32'h55667788);
        nops(1);

        // Reset drops the in-flight read but keeps storage.
        cmd(K_RD, 11'h010, 32'h0, 4'hF);
        nops(1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 11'h0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 11'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("t6_no_valid", {31'd0, VALID}, 32'd0);
            chk("t6_q_zero", Q, 32'h0);
            nops(1);
        end
        cmd(K_ACT, 11'h005, 32'h0, 4'hF);
        nops(4);
        cmd(K_RD, 11'h010, 32'h0, 4'hF);
        nops(4);
        chk("t6_kept_valid", {31'd0, VALID}, 32'd1);
        chk("t6_kept_q", Q, 32'hDEADBEEF);

        // Randomized traffic over a few rows, with column high bit set to exercise no-carry.
        for (int n = 0; n < 3000; n++) begin
            rr = int'($urandom_range(0, 99));
            if (rr < 1) begin
                cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 11'h0, 32'h0);
                continue;
            end
            if (rr < 25)      k = K_NOP;
            else if (rr < 40) k = K_ACT;
            else if (rr < 50) k = K_PRE;
            else if (rr < 72) k = K_RD;
            else if (rr < 95) k = K_WR;
            else              k = K_ILL;
            if (k == K_ACT) a = 11'(5 + $urandom_range(0, 2));
            else            a = 11'($urandom_range(0, 7)) | (11'($urandom_range(0, 1)) << 10);
            if (k == K_NOP && $urandom_range(0, 1) == 1)
                cycle(1'b0, 1'b1, 1'($urandom), 1'($urandom), 4'($urandom), a, $urandom);
            else
                cmd(k, a, $urandom, 4'($urandom_range(0, 14)));
        end
        model_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
